serial_subtractor_ctrl: RTL
===========================

# serial_subtractor_ctrl

Bit-serial subtract engine that time-shares a single `fullSubtractor` cell across a WIDTH-bit operation. It accepts operands A, B and a borrow-in over a valid/ready handshake, then steps the cell once per clock from LSB to MSB, carrying the borrow in a flip-flop. It returns the difference and final borrow over a second valid/ready handshake. It is the small-area alternative to a ripple array of `fullSubtractor` instances and sits between an operand source and a result consumer.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- in_valid  input  1  operand source has A/B/bin valid.
- in_ready  output  1  block can accept operands; high only in IDLE.
- in_a  input  WIDTH  minuend.
- in_b  input  WIDTH  subtrahend.
- in_bin  input  1  borrow-in to bit 0.
- out_valid  output  1  result valid; high only in DONE.
- out_ready  input  1  consumer accepts result.
- out_diff  output  WIDTH  difference = (in_a - in_b - in_bin) mod 2^WIDTH.
- out_bout  output  1  borrow-out of MSB; 1 iff in_a < in_b + in_bin (unsigned).
- busy  output  1  high in RUN and DONE.

## Operation
- State machine: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid=1: latch in_a into shift reg SA, in_b into SB, in_bin into borrow FF BR; clear bit counter CNT; go to RUN.
- RUN, each cycle:
  - The single `fullSubtractor` gets a=SA[0], b=SB[0], bur=BR.
  - At the clock edge:
    - difference bit shifts into the MSB of result reg SD (SD shifts right);
    - SA and SB shift right;
    - BR ← cell borrow;
    - CNT increments.
  - When CNT==WIDTH-1 at the edge, go to DONE.
- DONE:
  - out_valid=1; out_diff=SD; out_bout=BR.
  - Both are held stable until out_ready=1.
  - On out_ready=1, go to IDLE.
- CNT is $clog2(WIDTH) bits wide. It never wraps within an operation and is not used outside RUN.
- in_valid in RUN/DONE is ignored (in_ready=0); no operand is lost or double-captured.
- out_ready outside DONE has no effect.
- The bit cell is the existing `fullSubtractor`; no alternate subtract logic is inferred.

## Timing
- Reset (rst_n=0, any state, including mid-RUN or DONE):
  - immediately state=IDLE;
  - SA, SB, SD, BR, CNT = 0;
  - out_valid=0, out_diff=0, out_bout=0, busy=0, in_ready=1.
  - No partial result is ever presented after reset.
- Accept edge T (in_valid & in_ready): RUN occupies the cycles after edges T..T+WIDTH-1.
- out_valid rises after edge T+WIDTH, i.e. latency = WIDTH cycles from accept to out_valid.
- Result consumed at the first edge with out_valid & out_ready. in_ready is high from the next cycle.
- Minimum initiation interval is WIDTH+2 cycles: accept, WIDTH-1 further RUN edges, DONE, IDLE.
- Back-pressure: out_ready low for any number of cycles keeps DONE; outputs are unchanged.
- in_ready, out_valid and busy are decoded from state registers only; there are no combinational input-to-output paths.

## Test plan
- WIDTH=8; A=0x5A, B=0x3C, bin=0 -> out_diff=0x1E, out_bout=0; out_valid exactly 8 cycles after the accept edge.
- A=0x00, B=0x01, bin=0 -> out_diff=0xFF, out_bout=1; A=0x10, B=0x10, bin=1 -> 0xFF, bout=1; A=0xFF, B=0x00, bin=1 -> 0xFE, bout=0.
- Hold out_ready=0 for 5 cycles in DONE with new in_valid/in_a toggling -> outputs stay 0x1E/0, in_ready stays 0, no new capture; release -> IDLE next cycle.
- Assert rst_n=0 asynchronously after the 3rd RUN edge -> outputs 0 and in_ready=1 without waiting for a clock edge. After release, the next op (A=0x80, B=0x7F) -> 0x01, bout=0.
- Back-to-back: in_valid held high with out_ready=1 over 4 ops -> accepts spaced exactly 10 cycles apart; results match a reference model.
- Random: 1000 random A/B/bin at WIDTH=8 and WIDTH=2, with random out_ready stalls -> every result equals (A-B-bin) mod 2^WIDTH and borrow matches; no dropped or duplicated transactions.

Source files
------------

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial WIDTH-bit subtractor: one fullSubtractor cell stepped LSB to MSB,
// with a valid/ready handshake for operands and another for the result.

module fullSubtractor (
  input  logic a,
  input  logic b,
  input  logic bur,
  output logic diff,
  output logic bout
);
  assign diff = a ^ b ^ bur;
  assign bout = (~a & b) | (~(a ^ b) & bur);
endmodule

module serial_subtractor_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_diff,
  output logic             out_bout,
  output logic             busy
);
  // state   | meaning
  // S_IDLE  | waiting for operands, in_ready high
  // S_RUN   | one difference bit per cycle, LSB first
  // S_DONE  | result held until the consumer takes it
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] sd_q, sd_d;
  logic             br_q, br_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             cell_diff, cell_bout;
  logic             last_bit;

  fullSubtractor u_cell (
    .a    (sa_q[0]),
    .b    (sb_q[0]),
    .bur  (br_q),
    .diff (cell_diff),
    .bout (cell_bout)
  );

  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      sd_q    <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      sd_q    <= sd_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    sd_d    = sd_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          sa_d    = in_a;
          sb_d    = in_b;
          sd_d    = '0;
          br_d    = in_bin;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        sd_d = {cell_diff, sd_q[WIDTH-1:1]};
        sa_d = sa_q >> 1;
        sb_d = sb_q >> 1;
        br_d = cell_bout;
        // Counter stops at WIDTH-1 so it never wraps inside an operation.
        if (last_bit) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Result is gated by DONE so no partially shifted value ever shows up.
  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_RUN) || (state_q == S_DONE);
  assign out_diff  = out_valid ? sd_q : '0;
  assign out_bout  = out_valid & br_q;

endmodule
